control_writeback: RTL

Writeback-stage controller and the reading end of the Execute→Writeback buffer. It captures entries pushed by the execute controller's ExeWBBufferWr strobe into a small FIFO and pops them in order. For loads it performs a memory read handshake first. It then drives the register-file write port and raises a full flag so execute can stall.

---
 rtl/control_writeback.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/control_writeback.sv
// Purpose : writeback-stage controller and reading end of the execute->writeback buffer;
//           pops buffered results in order, runs a read handshake for loads, drives the RF write port.
// Latency : ALU entry pushed at edge N is written at edge N+3; a load adds one cycle plus memory wait cycles.
// Backpr. : ExeWBFull (registered occupancy == DEPTH) stalls execute; a push while full is dropped and
//           recorded in sticky WBOverflow; the pop side stalls for as long as memory withholds MemRdAck.
// Ports   : CLK/RST (async active-low) | Exe* push side (strobe, dst, data/address, flags) + ExeWBFull |
//           MemRdReq/MemAddr/MemRdData/MemRdAck read handshake | RegWrEn/RegWrAddr/RegWrData RF port |
//           WBBusy, BufCount, WBOverflow status.
module control_writeback #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ExeWBBufferWr,
    input  logic [REG_ADDR_W-1:0] ExeDst,
    input  logic [DATA_W-1:0]     ExeData,
    input  logic                  ExeRegWrite,
    input  logic                  ExeIsLoad,
    output logic                  ExeWBFull,
    output logic                  MemRdReq,
    output logic [DATA_W-1:0]     MemAddr,
    input  logic [DATA_W-1:0]     MemRdData,
    input  logic                  MemRdAck,
    output logic                  RegWrEn,
    output logic [REG_ADDR_W-1:0] RegWrAddr,
    output logic [DATA_W-1:0]     RegWrData,
    output logic                  WBBusy,
    output logic [PTR_W:0]        BufCount,
    output logic                  WBOverflow
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
        logic                  reg_write;
        logic                  is_load;
    } entry_t;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_READ  = 2'd1,
        WB_MEM   = 2'd2,
        WB_WRITE = 2'd3
    } wb_state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    wb_state_t             state_q, state_d;
    entry_t                fifo_q [DEPTH];
    entry_t                fifo_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [REG_ADDR_W-1:0] hold_dst_q, hold_dst_d;
    logic [DATA_W-1:0]     hold_data_q, hold_data_d;
    logic                  hold_rw_q, hold_rw_d;

    entry_t in_entry;
    entry_t head;
    logic   full;
    logic   push;
    logic   pop;
    logic   buf_nonempty;

    assign in_entry     = {ExeDst, ExeData, ExeRegWrite, ExeIsLoad};
    assign head         = fifo_q[rd_ptr_q];
    assign full         = (count_q == FULL_CNT);
    assign buf_nonempty = (count_q != '0);
    // A push seen while full is dropped outright, even if this cycle also pops.
    assign push         = ExeWBBufferWr & ~full;
    // READ is only ever entered with a non-empty buffer, so the pop is always valid.
    assign pop          = (state_q == WB_READ);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: begin
                if (buf_nonempty) begin
                    state_d = WB_READ;
                end
            end
            WB_READ: begin
                // Routing uses the head entry directly, as it is being latched this cycle.
                if (head.is_load) begin
                    state_d = WB_MEM;
                end else if (head.reg_write) begin
                    state_d = WB_WRITE;
                end else begin
                    state_d = WB_IDLE;
                end
            end
            WB_MEM: begin
                if (MemRdAck) begin
                    state_d = hold_rw_q ? WB_WRITE : WB_IDLE;
                end
            end
            WB_WRITE: begin
                // Go straight back to READ so ALU entries drain at one per two cycles.
                state_d = buf_nonempty ? WB_READ : WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: Moore-decoded control outputs
    // ------------------------------------------------------------------
    always_comb begin
        MemRdReq = 1'b0;
        RegWrEn  = 1'b0;
        WBBusy   = 1'b1;
        case (state_q)
            WB_IDLE:  WBBusy   = 1'b0;
            WB_MEM:   MemRdReq = 1'b1;
            // R0 is hardwired zero: the WRITE cycle still happens, the strobe does not.
            WB_WRITE: RegWrEn  = (hold_dst_q != '0);
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Buffer, occupancy, overflow flag and holding registers
    // ------------------------------------------------------------------
    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (ExeWBBufferWr & full);
        hold_dst_d  = hold_dst_q;
        hold_data_d = hold_data_q;
        hold_rw_d   = hold_rw_q;

        if (push) begin
            fifo_d[wr_ptr_q] = in_entry;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (state_q == WB_READ) begin
            hold_dst_d  = head.dst;
            hold_data_d = head.data;
            hold_rw_d   = head.reg_write;
        end else if ((state_q == WB_MEM) && MemRdAck) begin
            // Load data replaces the address in the same holding register.
            hold_data_d = MemRdData;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            hold_dst_q  <= '0;
            hold_data_q <= '0;
            hold_rw_q   <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            hold_dst_q  <= hold_dst_d;
            hold_data_q <= hold_data_d;
            hold_rw_q   <= hold_rw_d;
        end
    end

    assign ExeWBFull  = full;
    assign BufCount   = count_q;
    assign WBOverflow = overflow_q;
    assign MemAddr    = hold_data_q;
    assign RegWrAddr  = hold_dst_q;
    assign RegWrData  = hold_data_q;

endmodule
